arbiter_wrr_lock: RTL and testbench

//  Weighted round-robin arbiter with transaction locking for a shared resource.
//  - Requesters issue multi-beat transactions; each transaction ends on a beat flagged by last[i].
//  - A granted port keeps the resource for up to weight[i] complete transactions.
//  - Sits between N requesters and a shared datapath or bus port, which supplies ready.

---
 rtl/arbiter_wrr_lock.sv | 143 ++++++++++++++
 tb/tb_arbiter_wrr_lock.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_wrr_lock.sv
// rtl/arbiter_wrr_lock.sv - weighted round-robin arbiter with per-grant transaction locking
// A granted port keeps the resource for up to weight[i] whole transactions, then rotates downward.
module arbiter_wrr_lock #(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 4,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          request,
    input  logic [NUM_PORTS-1:0]          last,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weights,
    input  logic                          ready,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          active,
    output logic                          beat
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PORTS-1:0] grant_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic [WEIGHT_W-1:0]  credit;
    logic [WEIGHT_W-1:0]  credit_nxt;
    logic                 in_txn;
    logic                 in_txn_nxt;
    logic [IDX_W-1:0]     scan_idx;
    logic                 scan_found;
    logic                 release_now;
    logic                 cur_req;
    logic                 cur_last;
    logic [WEIGHT_W-1:0]  weight_arr [NUM_PORTS];
    logic [WEIGHT_W-1:0]  scan_weight;

    // (base - step) mod NUM_PORTS, valid for any port count, not only powers of two
    function automatic logic [IDX_W-1:0] wrap_down(input logic [IDX_W-1:0] base, input int step);
        int t;
        t = (int'(base) - step + NUM_PORTS) % NUM_PORTS;
        return t[IDX_W-1:0];
    endfunction

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_weight
        assign weight_arr[gi] = weights[gi*WEIGHT_W +: WEIGHT_W];
    end

    assign active   = |grant;
    assign cur_req  = request[grant_idx];
    assign cur_last = last[grant_idx];
    assign beat     = active & cur_req & ready;

    // Downward priority scan starting at ptr; the first hit wins.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!scan_found && request[wrap_down(ptr, i)]) begin
                scan_found = 1'b1;
                scan_idx   = wrap_down(ptr, i);
            end
        end
    end

    assign scan_weight = weight_arr[scan_idx];

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        ptr_nxt     = ptr;
        credit_nxt  = credit;
        in_txn_nxt  = in_txn;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                if (scan_found) begin
                    state_nxt            = GRANT;
                    grant_nxt            = '0;
                    grant_nxt[scan_idx]  = 1'b1;
                    idx_nxt              = scan_idx;
                    credit_nxt           = (scan_weight == '0) ? WEIGHT_W'(1) : scan_weight;
                    in_txn_nxt           = 1'b0;
                end
            end
            GRANT: begin
                if (beat) begin
                    if (cur_last) begin
                        in_txn_nxt = 1'b0;
                        credit_nxt = credit - WEIGHT_W'(1);
                        if (credit == WEIGHT_W'(1)) begin
                            release_now = 1'b1;
                        end
                    end else begin
                        in_txn_nxt = 1'b1;
                    end
                end else if (!cur_req && !in_txn) begin
                    release_now = 1'b1;
                end
                // A request dropped mid-transaction matches neither branch: the lock holds.
                if (release_now) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    in_txn_nxt = 1'b0;
                    ptr_nxt    = wrap_down(grant_idx, 1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= IDX_W'(NUM_PORTS - 1);
            credit    <= '0;
            in_txn    <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            ptr       <= ptr_nxt;
            credit    <= credit_nxt;
            in_txn    <= in_txn_nxt;
        end
    end

    grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    credit_live_a:  assert property (@(posedge clk) disable iff (rst) active |-> (credit != '0));

endmodule

// File: tb/tb_arbiter_wrr_lock.sv
// tb/tb_arbiter_wrr_lock.sv - directed scenarios plus randomized run against a behavioural model
module tb_arbiter_wrr_lock;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] request;
    logic [N-1:0] last;
    logic [4*N-1:0] weights;
    logic         ready;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         active;
    logic         beat;

    int pass_cnt  = 0;
    int total_cnt = 0;

    arbiter_wrr_lock #(.NUM_PORTS(N), .WEIGHT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .last      (last),
        .weights   (weights),
        .ready     (ready),
        .grant     (grant),
        .grant_idx (grant_idx),
        .active    (active),
        .beat      (beat)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        request = '0;
        last    = '0;
        ready   = 1'b0;
        weights = 16'h1111;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++;
        if (grant !== 4'b0000) $display("FAIL reset_grant got %b want 0000", grant);
        else pass_cnt++;
        total_cnt++;
        if (grant_idx !== 2'd0) $display("FAIL reset_grant_idx got %0d want 0", grant_idx);
        else pass_cnt++;
        total_cnt++;
        if (active !== 1'b0 || beat !== 1'b0) $display("FAIL reset_active_beat got %b%b want 00", active, beat);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp [9] = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
                                4'b0000, 4'b0001, 4'b0000, 4'b1000};
        do_reset();
        request = 4'b1111; last = 4'b1111; weights = 16'h1111; ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            total_cnt++;
            if (grant !== exp[i]) $display("FAIL rotation cycle %0d grant %b want %b", i, grant, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (beat !== (exp[i] != 4'b0000)) $display("FAIL rotation_beat cycle %0d got %b", i, beat);
            else pass_cnt++;
        end
    endtask

    task automatic test_weighted();
        logic [3:0] exp [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
        do_reset();
        request = 4'b0101; last = 4'b1111; weights = 16'h1311; ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            total_cnt++;
            if (grant !== exp[i]) $display("FAIL weighted cycle %0d grant %b want %b", i, grant, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ready_stall();
        logic rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        request = 4'b1001; last = 4'b0000; weights = 16'h1111; ready = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            ready = rdy[i];
            last  = (i == 5) ? 4'b1000 : 4'b0000;
            #1;
            total_cnt++;
            if (grant !== 4'b1000 || beat !== rdy[i])
                $display("FAIL stall cycle %0d grant %b beat %b want 1000 %b", i, grant, beat, rdy[i]);
            else pass_cnt++;
            cyc();
        end
        total_cnt++;
        if (grant !== 4'b0000) $display("FAIL stall_release grant %b want 0000", grant);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (grant !== 4'b0001) $display("FAIL stall_next grant %b want 0001", grant);
        else pass_cnt++;
    endtask

    task automatic test_zero_weight();
        do_reset();
        request = 4'b0010; last = 4'b1111; weights = 16'h1101; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total_cnt++;
            if (grant !== ((i % 2 == 0) ? 4'b0010 : 4'b0000))
                $display("FAIL zero_weight cycle %0d grant %b", i, grant);
            else pass_cnt++;
        end
    endtask

    task automatic test_drop();
        do_reset();
        request = 4'b0100; last = 4'b1111; weights = 16'h1411; ready = 1'b1;
        cyc();
        cyc();
        request = 4'b0000;
        #1;
        total_cnt++;
        if (grant !== 4'b0100 || beat !== 1'b0) $display("FAIL drop_idle_hold grant %b beat %b", grant, beat);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (grant !== 4'b0000) $display("FAIL drop_idle_release grant %b want 0000", grant);
        else pass_cnt++;

        do_reset();
        request = 4'b0100; last = 4'b0000; weights = 16'h1411; ready = 1'b1;
        cyc();
        cyc();
        request = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (grant !== 4'b0100 || beat !== 1'b0)
                $display("FAIL drop_locked cycle %0d grant %b beat %b want 0100 0", i, grant, beat);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        request = 4'b0010; last = 4'b0000; weights = 16'h1111; ready = 1'b1;
        cyc();
        cyc();
        total_cnt++;
        if (grant !== 4'b0010) $display("FAIL midrst_pre grant %b want 0010", grant);
        else pass_cnt++;
        rst = 1'b1;
        request = 4'b1010;
        cyc();
        total_cnt++;
        if (grant !== 4'b0000) $display("FAIL midrst_clear grant %b want 0000", grant);
        else pass_cnt++;
        rst = 1'b0;
        cyc();
        total_cnt++;
        if (grant !== 4'b1000) $display("FAIL midrst_next grant %b want 1000", grant);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int owner = -1;
        int credits_left = 0;
        bit mid = 1'b0;
        int ptr = N - 1;
        bit exp_beat;
        logic [N-1:0] exp_grant;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            request = 4'($urandom);
            if (owner >= 0 && $urandom_range(0, 9) != 0) request[owner] = 1'b1;
            last    = 4'($urandom);
            ready   = ($urandom_range(0, 3) != 0);
            weights = 16'($urandom);
            #1;
            exp_grant = (owner < 0) ? 4'b0000 : 4'(1 << owner);
            exp_beat  = (owner >= 0) && request[owner] && ready;
            total_cnt++;
            if (grant !== exp_grant) $display("FAIL random_grant cycle %0d got %b want %b", c, grant, exp_grant);
            else pass_cnt++;
            total_cnt++;
            if (beat !== exp_beat) $display("FAIL random_beat cycle %0d got %b want %b", c, beat, exp_beat);
            else pass_cnt++;
            if (owner >= 0) begin
                total_cnt++;
                if (grant_idx !== 2'(owner)) $display("FAIL random_idx cycle %0d got %0d want %0d", c, grant_idx, owner);
                else pass_cnt++;
            end
            if (owner < 0) begin
                for (int s = 0; s < N; s++) begin
                    int p;
                    p = (ptr - s + N) % N;
                    if (owner < 0 && request[p]) begin
                        owner = p;
                        credits_left = int'(weights[p*4 +: 4]);
                        if (credits_left == 0) credits_left = 1;
                        mid = 1'b0;
                    end
                end
            end else begin
                bit drop;
                drop = 1'b0;
                if (exp_beat) begin
                    if (last[owner]) begin
                        mid = 1'b0;
                        credits_left = credits_left - 1;
                        drop = (credits_left == 0);
                    end else begin
                        mid = 1'b1;
                    end
                end else if (!request[owner] && !mid) begin
                    drop = 1'b1;
                end
                if (drop) begin
                    ptr   = (owner + N - 1) % N;
                    owner = -1;
                    mid   = 1'b0;
                end
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_weighted();
        test_ready_stall();
        test_zero_weight();
        test_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
